// File: rtl/bcd_to_score_if.sv
// Handshake bundle for bcd_to_score.
//   slave  : converter side (takes the BCD word and i_ready, returns the result)
//   master : upstream/downstream side (drives the BCD word and i_ready)
// Signals:
//   i_valid/o_ready          : BCD word handshake
//   i_bcd                    : packed BCD, most significant digit in the top nibble
//   o_valid/i_ready          : result handshake
//   o_value                  : saturated binary result
//   o_overflow/o_bad_digit   : result flags, held with o_value
//   o_busy                   : conversion or result pending
interface bcd_to_score_if #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned OUT_W = 10
);
  logic                i_valid;
  logic                o_ready;
  logic [4*NDIG-1:0]   i_bcd;
  logic                o_valid;
  logic                i_ready;
  logic [OUT_W-1:0]    o_value;
  logic                o_overflow;
  logic                o_bad_digit;
  logic                o_busy;

  modport slave (
    input  i_valid, i_bcd, i_ready,
    output o_ready, o_valid, o_value, o_overflow, o_bad_digit, o_busy
  );

  modport master (
    output i_valid, i_bcd, i_ready,
    input  o_ready, o_valid, o_value, o_overflow, o_bad_digit, o_busy
  );
endinterface

// File: rtl/bcd_to_score.sv
// Sequential packed-BCD to binary converter with a saturated result.
// One multiply-by-10-and-add step per cycle, most significant digit first.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : bcd_to_score_if.slave (word handshake in, result handshake out, busy)
module bcd_to_score #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned OUT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_to_score_if.slave        bus
);

  localparam int unsigned AccW = 4 * NDIG;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CmpW = (AccW > OUT_W) ? AccW : OUT_W;
  localparam logic [CmpW-1:0] MaxVal = CmpW'({OUT_W{1'b1}});

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              bad_q, bad_d;
  logic [OUT_W-1:0]  value_q, value_d;
  logic              ovf_q, ovf_d;
  logic              bad_out_q, bad_out_d;

  logic [3:0]        digit;
  logic [AccW-1:0]   acc_next;
  logic              bad_next;
  logic              sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      bad_q     <= 1'b0;
      value_q   <= '0;
      ovf_q     <= 1'b0;
      bad_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      bad_q     <= bad_d;
      value_q   <= value_d;
      ovf_q     <= ovf_d;
      bad_out_q <= bad_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    bad_d     = bad_q;
    value_d   = value_q;
    ovf_d     = ovf_q;
    bad_out_d = bad_out_q;

    // The captured word shifts left each step, so the current digit is always the top nibble.
    digit    = bcd_q[AccW-1 -: 4];
    // acc*10 = acc*8 + acc*2; AccW bits hold even all-0xF words, so no wrap.
    acc_next = (acc_q << 3) + (acc_q << 1) + AccW'(digit);
    bad_next = bad_q | (digit > 4'd9);
    sat      = CmpW'(acc_next) > MaxVal;

    unique case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          bcd_d   = bus.i_bcd;
          acc_d   = '0;
          cnt_d   = '0;
          bad_d   = 1'b0;
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d = acc_next;
        bad_d = bad_next;
        bcd_d = bcd_q << 4;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(NDIG - 1)) begin
          value_d   = sat ? '1 : OUT_W'(acc_next);
          ovf_d     = sat;
          bad_out_d = bad_next;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus.i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.o_ready     = (state_q == StIdle);
  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_valid     = (state_q == StDone);
  assign bus.o_value     = value_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_bad_digit = bad_out_q;

endmodule
